// File: rtl/nes_poll_scheduler.sv
// rtl/nes_poll_scheduler.sv - poll sequencer, button snapshot and sticky press events for the NES pad interface
// Optional NES_POLL_DEBOUNCE_EN: a snapshot bit only changes after two consecutive captures agree.
module nes_poll_scheduler #(
   parameter int NUM_CONTROLLERS = 4,
   parameter int POLL_PERIOD     = 16667,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable_i,
   input  logic                         req_i,
   input  logic                         ack_i,
   output logic                         start_fetch_o,
   input  logic                         valid_i,
   input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
   output logic [8*NUM_CONTROLLERS-1:0] snapshot_o,
   output logic [8*NUM_CONTROLLERS-1:0] pressed_o,
   output logic                         update_o,
   output logic                         busy_o,
   output logic                         fault_o
);

   localparam int W   = 8 * NUM_CONTROLLERS;
   localparam int TW  = ($clog2(POLL_PERIOD) > 0) ? $clog2(POLL_PERIOD) : 1;
   localparam int WDW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_PERIOD - 1);
   localparam logic [WDW-1:0] WD_LAST      = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CAPTURE
   } state_e;

   state_e         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           pending_q, pending_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           fault_q, fault_d;
   logic [W-1:0]   snapshot_q, snapshot_d;
   logic [W-1:0]   pressed_q, pressed_d;
   logic [W-1:0]   snap_capture;
   logic           timer_expire;
   logic           wd_timeout;
   logic           timeout_hit;

   assign timer_expire = enable_i && (timer_q == '0);
   assign wd_timeout   = (wd_q == WD_LAST);
   // Progress on valid_i wins over a watchdog expiry in the same cycle.
   assign timeout_hit  = wd_timeout &&
                         (((state_q == S_WAIT_BUSY) &&  valid_i) ||
                          ((state_q == S_WAIT_DONE) && !valid_i));

`ifdef NES_POLL_DEBOUNCE_EN
   logic [W-1:0] cand_q, cand_d;
   logic [W-1:0] disagree;

   assign disagree     = data_LIST_i ^ cand_q;
   assign snap_capture = (data_LIST_i & ~disagree) | (snapshot_q & disagree);
   assign cand_d       = (state_q == S_CAPTURE) ? data_LIST_i : cand_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= '0;
      end else begin
         cand_q <= cand_d;
      end
   end
`else
   assign snap_capture = data_LIST_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (pending_q && valid_i) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!valid_i)        state_d = S_WAIT_DONE;
            else if (wd_timeout) state_d = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (valid_i)         state_d = S_CAPTURE;
            else if (wd_timeout) state_d = S_IDLE;
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      start_fetch_o = (state_q == S_ISSUE);
      update_o      = (state_q == S_CAPTURE);
      busy_o        = (state_q != S_IDLE);
   end

   always_comb begin
      timer_d = timer_q;
      if (enable_i) timer_d = timer_expire ? TIMER_RELOAD : timer_q - 1'b1;

      // A source event during ISSUE re-arms pending so another poll follows.
      pending_d = ((state_q == S_ISSUE) ? 1'b0 : pending_q) | timer_expire | req_i;

      wd_d = wd_q;
      case (state_q)
         S_ISSUE:     wd_d = '0;
         S_WAIT_BUSY: wd_d = valid_i ? wd_q + 1'b1 : '0;
         S_WAIT_DONE: wd_d = wd_q + 1'b1;
         default:     wd_d = wd_q;
      endcase

      fault_d = fault_q;
      if (timeout_hit)                 fault_d = 1'b1;
      else if (state_q == S_CAPTURE)   fault_d = 1'b0;

      snapshot_d = snapshot_q;
      pressed_d  = ack_i ? '0 : pressed_q;
      if (state_q == S_CAPTURE) begin
         snapshot_d = snap_capture;
         pressed_d  = (pressed_q & ~{W{ack_i}}) | (snap_capture & ~snapshot_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q    <= TIMER_RELOAD;
         pending_q  <= 1'b0;
         wd_q       <= '0;
         fault_q    <= 1'b0;
         snapshot_q <= '0;
         pressed_q  <= '0;
      end else begin
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         wd_q       <= wd_d;
         fault_q    <= fault_d;
         snapshot_q <= snapshot_d;
         pressed_q  <= pressed_d;
      end
   end

   assign snapshot_o = snapshot_q;
   assign pressed_o  = pressed_q;
   assign fault_o    = fault_q;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb/tb_nes_poll_scheduler.sv - directed table-driven bench for nes_poll_scheduler
module tb_nes_poll_scheduler;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable_i = 1'b0;
   logic         req_i = 1'b0;
   logic         ack_i = 1'b0;
   logic         valid_i = 1'b1;
   logic [W-1:0] data_i = '0;
   logic [W-1:0] model_data = '0;
   logic         hang = 1'b0;
   logic         start_fetch_o, update_o, busy_o, fault_o;
   logic [W-1:0] snapshot_o, pressed_o;

   int  fetch_cnt = 0;
   int  start_total = 0;
   int  overlap = 0;
   logic prev_start = 1'b0;
   int  total = 0;
   int  bad = 0;

   typedef struct {
      logic [7:0] d;
      logic       ack;
      logic [7:0] snap;
      logic [7:0] prs;
   } vec_t;
   vec_t tbl[6];
   logic [7:0] deb_in[5];
   logic [7:0] deb_exp[5];

   nes_poll_scheduler #(
      .NUM_CONTROLLERS(2),
      .POLL_PERIOD(100),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable_i(enable_i),
      .req_i(req_i),
      .ack_i(ack_i),
      .start_fetch_o(start_fetch_o),
      .valid_i(valid_i),
      .data_LIST_i(data_i),
      .snapshot_o(snapshot_o),
      .pressed_o(pressed_o),
      .update_o(update_o),
      .busy_o(busy_o),
      .fault_o(fault_o)
   );

   always #5 clk = ~clk;

   // Interface model: 10-cycle fetch, data presented as valid_i re-asserts.
   always @(negedge clk) begin
      if (rst) begin
         valid_i = 1'b1;
         fetch_cnt = 0;
      end else if (start_fetch_o && !hang) begin
         valid_i = 1'b0;
         fetch_cnt = 10;
      end else if (fetch_cnt > 0) begin
         fetch_cnt = fetch_cnt - 1;
         if (fetch_cnt == 0) begin
            data_i = model_data;
            valid_i = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (start_fetch_o) begin
         start_total = start_total + 1;
         if (prev_start) overlap = overlap + 1;
      end
      prev_start = start_fetch_o;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_update(input string name);
      int n;
      n = 0;
      while (update_o !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk(name, {31'd0, update_o}, 32'd1);
   endtask

   task automatic do_fetch(input logic [7:0] d, input logic ack, input string name);
      model_data = {8'h00, d};
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      wait_update(name);
      ack_i = ack;
      step();
      ack_i = 1'b0;
   endtask

   initial begin
      int n;
      int s0;
      logic upd_seen;
      logic [7:0] exp_wd_prs;
      logic [7:0] exp_per_snap;

`ifdef NES_POLL_DEBOUNCE_EN
      tbl[0] = '{8'h81, 1'b0, 8'h00, 8'h00};
      tbl[1] = '{8'h83, 1'b0, 8'h81, 8'h81};
      tbl[2] = '{8'h87, 1'b1, 8'h83, 8'h02};
      tbl[3] = '{8'h00, 1'b0, 8'h83, 8'h02};
      tbl[4] = '{8'hFF, 1'b1, 8'h83, 8'h00};
      tbl[5] = '{8'h0F, 1'b0, 8'h8F, 8'h0C};
      exp_wd_prs   = 8'h0C;
      exp_per_snap = 8'h00;
      deb_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
      tbl[0] = '{8'h81, 1'b0, 8'h81, 8'h81};
      tbl[1] = '{8'h83, 1'b0, 8'h83, 8'h83};
      tbl[2] = '{8'h87, 1'b1, 8'h87, 8'h04};
      tbl[3] = '{8'h00, 1'b0, 8'h00, 8'h04};
      tbl[4] = '{8'hFF, 1'b1, 8'hFF, 8'hFF};
      tbl[5] = '{8'h0F, 1'b0, 8'h0F, 8'hFF};
      exp_wd_prs   = 8'hFF;
      exp_per_snap = 8'h81;
      deb_exp = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
`endif
      deb_in = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01};

      step();
      step();
      chk("rst_start", {31'd0, start_fetch_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_fault", {31'd0, fault_o}, 32'd0);
      chk("rst_snap", {16'd0, snapshot_o}, 32'd0);
      rst = 1'b0;

      // Run the timer partway so a later reset has to reload it.
      enable_i = 1'b1;
      repeat (30) step();
      enable_i = 1'b0;
      chk("timer_no_early_poll", {31'd0, busy_o}, 32'd0);

      model_data = '0;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      chk("lat_cycle1", {31'd0, start_fetch_o}, 32'd0);
      step();
      chk("lat_cycle2", {31'd0, start_fetch_o}, 32'd1);
      wait_update("lat_update");
      step();

      for (int i = 0; i < 6; i++) begin
         do_fetch(tbl[i].d, tbl[i].ack, $sformatf("tbl%0d_update", i));
         chk($sformatf("tbl%0d_snap", i), {16'd0, snapshot_o}, {24'd0, tbl[i].snap});
         chk($sformatf("tbl%0d_pressed", i), {16'd0, pressed_o}, {24'd0, tbl[i].prs});
      end

      s0 = start_total;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      n = 0;
      while (start_fetch_o !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("busy_first_start", {31'd0, start_fetch_o}, 32'd1);
      step();
      step();
      step();
      chk("busy_during", {31'd0, busy_o}, 32'd1);
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      step();
      step();
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      wait_update("busy_first_update");
      step();
      chk("busy_idle_gap", {31'd0, start_fetch_o}, 32'd0);
      step();
      chk("busy_reissue", {31'd0, start_fetch_o}, 32'd1);
      wait_update("busy_second_update");
      repeat (30) step();
      chk("busy_start_count", start_total - s0, 32'd2);
      chk("no_overlap", overlap, 32'd0);

      hang = 1'b1;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      step();
      chk("wd_issue", {31'd0, start_fetch_o}, 32'd1);
      repeat (16) step();
      chk("wd_not_yet", {31'd0, fault_o}, 32'd0);
      chk("wd_still_busy", {31'd0, busy_o}, 32'd1);
      step();
      chk("wd_fault", {31'd0, fault_o}, 32'd1);
      chk("wd_idle", {31'd0, busy_o}, 32'd0);
      chk("wd_snap_kept", {16'd0, snapshot_o}, 32'h0F);
      chk("wd_pressed_kept", {16'd0, pressed_o}, {24'd0, exp_wd_prs});
      hang = 1'b0;
      do_fetch(8'h0F, 1'b0, "wd_recover_update");
      chk("wd_fault_cleared", {31'd0, fault_o}, 32'd0);

      model_data = 16'h0081;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      step();
      step();
      step();
      step();
      chk("rst_mid_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      step();
      chk("rstm_start", {31'd0, start_fetch_o}, 32'd0);
      chk("rstm_update", {31'd0, update_o}, 32'd0);
      chk("rstm_busy", {31'd0, busy_o}, 32'd0);
      chk("rstm_snap", {16'd0, snapshot_o}, 32'd0);
      chk("rstm_pressed", {16'd0, pressed_o}, 32'd0);
      rst = 1'b0;
      enable_i = 1'b1;

      n = 0;
      while (start_fetch_o !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk("timer_reload_first", n, 32'd101);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         upd_seen = 1'b0;
         do begin
            step();
            n++;
            if (update_o === 1'b1) upd_seen = 1'b1;
         end while (start_fetch_o !== 1'b1 && n < 300);
         chk($sformatf("period%0d", k), n, 32'd100);
         chk($sformatf("period%0d_update", k), {31'd0, upd_seen}, 32'd1);
         if (k == 0) begin
            chk("periodic_snap", {16'd0, snapshot_o}, {24'd0, exp_per_snap});
            chk("periodic_pressed", {16'd0, pressed_o}, {24'd0, exp_per_snap});
         end
      end

      enable_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_fetch(deb_in[i], 1'b0, $sformatf("deb%0d_update", i));
         chk($sformatf("deb%0d_snap", i), {16'd0, snapshot_o}, {24'd0, deb_exp[i]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nes_poll_scheduler.md
Name: nes_poll_scheduler

Overview:
Sequences the NES controller interface block. Issues its one-cycle start_fetch pulse periodically or on demand, and tracks its valid handshake through a full fetch. Captures the parallel button bytes into a stable snapshot and accumulates sticky per-button press events for the game/CPU side. Also detects a hung fetch via a watchdog.

Parameters:
NUM_CONTROLLERS, 4, number of controllers; data buses are 8*NUM_CONTROLLERS wide
POLL_PERIOD, 16667, cycles between automatic polls (>=2)
TIMEOUT_CYCLES, 64, maximum cycles allowed in each wait state before fault (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
enable_i  input  1  enables the periodic poll timer
req_i  input  1  on-demand poll request; single-cycle or level
ack_i  input  1  consumer acknowledge; clears pressed_o
start_fetch_o  output  1  one-cycle pulse to the interface
valid_i  input  1  interface idle/data-valid (high when idle)
data_LIST_i  input  8*NUM_CONTROLLERS  interface button bytes, active-high
snapshot_o  output  8*NUM_CONTROLLERS  last captured button state
pressed_o  output  8*NUM_CONTROLLERS  sticky rising-edge events since last ack
update_o  output  1  one-cycle pulse when snapshot_o changes register
busy_o  output  1  high in any state except IDLE
fault_o  output  1  sticky watchdog fault

Behaviour:
- Reset: state IDLE, timer=POLL_PERIOD-1, pending=0, all outputs 0 (snapshot_o, pressed_o, start_fetch_o, update_o, busy_o, fault_o). Reset mid-fetch aborts immediately; the interface is reset by the same rst.
- Poll timer: when enable_i=1, decrements each cycle. At 0 it sets pending and reloads to POLL_PERIOD-1. When enable_i=0 it holds its value.
- req_i=1 sets pending. Timer expiry and req_i in the same cycle merge into one pending poll.
- Any pending set while busy is retained. The next poll is issued directly after return to IDLE.
- States:
  - IDLE: if pending && valid_i, go to ISSUE.
  - ISSUE: start_fetch_o=1 for exactly this cycle; pending cleared; watchdog cleared; go to WAIT_BUSY.
  - WAIT_BUSY: wait for valid_i=0. On seeing it, clear the watchdog and go to WAIT_DONE.
  - WAIT_DONE: wait for valid_i=1, then go to CAPTURE. data_LIST_i is stable and final when valid_i re-asserts.
  - CAPTURE (1 cycle): snapshot_o<=data_LIST_i; pressed_o<=(pressed_o & ~{ack mask}) | (data_LIST_i & ~snapshot_o); update_o=1; go to IDLE.
- pending is set by a source (timer expiry or req_i) and cleared only in ISSUE. A source event in the ISSUE cycle itself re-sets pending, so another poll follows.
- ack_i clears all pressed_o bits. If ack_i coincides with CAPTURE, the old bits are cleared and the new edges from this capture are kept.
- Watchdog: an 8-bit-or-wider counter runs in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES-1:
  - fault_o<=1, go to IDLE; snapshot_o and pressed_o are unchanged.
  - fault_o clears only on rst or when a later fetch completes through CAPTURE.
- Latency: a req_i in IDLE with valid_i=1 gives start_fetch_o 2 cycles later (IDLE->ISSUE registered, pulse in ISSUE).
- Polls do not overlap: start_fetch_o is never asserted outside ISSUE.

Optional Feature:
Macro NES_POLL_DEBOUNCE_EN.
- Defined: a per-bit candidate register stores the previous capture. A snapshot bit changes only when two consecutive captures agree on the new value. pressed_o edges are computed from the debounced snapshot. update_o still pulses every CAPTURE.
- Undefined: no candidate register; snapshot_o takes data_LIST_i directly at every CAPTURE.

Test Plan:
- POLL_PERIOD=100, enable_i=1, interface model with 10-cycle fetch, controller 0 byte 0x81 -> start_fetch_o every 100 cycles; snapshot_o[7:0]=0x81 after first update_o; pressed_o[7:0]=0x81.
- Second capture 0x83 with no ack -> pressed_o[7:0]=0x83. Then ack_i in the CAPTURE cycle of a capture returning 0x87 -> pressed_o[7:0]=0x04.
- req_i pulsed twice while busy -> exactly one extra start_fetch_o after return to IDLE; no overlapping pulses.
- Interface model holds valid_i=1 after start, TIMEOUT_CYCLES=16 -> fault_o=1 after 16 cycles in WAIT_BUSY; snapshot unchanged; next good fetch clears fault_o.
- rst asserted in WAIT_DONE -> next cycle all outputs 0, state IDLE, timer reloaded to POLL_PERIOD-1.
- With NES_POLL_DEBOUNCE_EN: captures 0x00, 0x01, 0x00, 0x01, 0x01 -> snapshot_o[7:0] becomes 0x01 only after the fifth capture.
